pwm_capture: RTL

Measures an incoming PWM waveform and reports its duty as an 8-bit ratio (0–255), the same scale the servo PWM generator takes as `pwm_ratio`. It lets the subsystem read back a servo command line, an RC receiver channel or any external PWM source. It also reports raw high-time and period counts and flags loss of signal.

---
 rtl/pwm_capture.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its duty as an
// 8-bit ratio floor(256*high/period), raw high/period counts and loss of signal.
// Optional build macro PWM_CAPTURE_FILTER_EN adds a 3-sample glitch filter
// after the synchronizer (input latency 5 cycles instead of 3).

module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [7:0]       ratio,
  output logic             ratio_valid,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic             signal_lost
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  logic [1:0] sync;
  logic       cur;
  logic       prev;
  logic       rise;
  logic       fall;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic             div_busy, div_busy_nxt;
  logic [2:0]       div_iter, div_iter_nxt;
  logic [CNT_W:0]   div_rem, div_rem_nxt;
  logic [CNT_W-1:0] div_den, div_den_nxt;
  logic [CNT_W-1:0] div_hlat, div_hlat_nxt;
  logic [7:0]       div_quot, div_quot_nxt;
  logic [7:0]       ratio_nxt;
  logic             valid_nxt;
  logic [CNT_W-1:0] hc_nxt, pc_nxt;
  logic             lost_nxt;
  logic             meas_tmo;
  logic             period_close;

  logic [CNT_W:0]   rem_sh;
  logic             q_bit;
  logic [CNT_W:0]   rem_step;
  logic [7:0]       quot_step;

  // Two-flop synchronizer followed by the level/edge register
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pwm_in};
      prev <= cur;
      rise <= cur & ~prev;
      fall <= ~cur & prev;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist;

  // History of the two previous synced samples
  always_ff @(posedge clock) begin
    if (reset) hist <= '0;
    else       hist <= {hist[0], sync[1]};
  end

  // Level follows the line only after three consecutive equal samples
  always_comb begin
    cur = prev;
    if (sync[1] == hist[0] && sync[1] == hist[1]) cur = sync[1];
  end
`else
  // Unfiltered: every synced transition counts
  always_comb cur = sync[1];
`endif

  // One restoring-division step: shift, trial subtract, emit quotient bit
  always_comb begin
    rem_sh    = div_rem << 1;
    q_bit     = (rem_sh >= {1'b0, div_den});
    rem_step  = q_bit ? (rem_sh - {1'b0, div_den}) : rem_sh;
    quot_step = {div_quot[6:0], q_bit};
  end

  // Next-state: measurement FSM, timeout handling and divider sequencing
  always_comb begin
    state_nxt    = state;
    hcnt_nxt     = hcnt;
    pcnt_nxt     = pcnt;
    div_busy_nxt = div_busy;
    div_iter_nxt = div_iter;
    div_rem_nxt  = div_rem;
    div_den_nxt  = div_den;
    div_hlat_nxt = div_hlat;
    div_quot_nxt = div_quot;
    ratio_nxt    = ratio;
    valid_nxt    = 1'b0;
    hc_nxt       = high_count;
    pc_nxt       = period_count;
    lost_nxt     = signal_lost;
    meas_tmo     = 1'b0;
    period_close = 1'b0;

    // The divider runs to completion regardless of enable
    if (div_busy) begin
      div_rem_nxt  = rem_step;
      div_quot_nxt = quot_step;
      div_iter_nxt = div_iter + 3'd1;
      if (div_iter == 3'd7) begin
        div_busy_nxt = 1'b0;
        ratio_nxt    = quot_step;
        hc_nxt       = div_hlat;
        pc_nxt       = div_den;
        valid_nxt    = 1'b1;
        lost_nxt     = 1'b0;
      end
    end

    if (!enable) begin
      state_nxt = IDLE;
      hcnt_nxt  = '0;
      pcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_RISE;
          hcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_nxt = MEAS_HIGH;
            hcnt_nxt  = ONE;
            pcnt_nxt  = ONE;
          end else if (pcnt == TO) begin
            lost_nxt = 1'b1;
          end else begin
            pcnt_nxt = pcnt + ONE;
          end
        end
        MEAS_HIGH: begin
          if (pcnt == TO) begin
            meas_tmo = 1'b1;
          end else begin
            pcnt_nxt = pcnt + ONE;
            if (fall) state_nxt = MEAS_LOW;
            else      hcnt_nxt  = hcnt + ONE;
          end
        end
        MEAS_LOW: begin
          if (pcnt == TO) begin
            meas_tmo = 1'b1;
          end else if (rise) begin
            period_close = 1'b1;
            state_nxt    = MEAS_HIGH;
            hcnt_nxt     = ONE;
            pcnt_nxt     = ONE;
          end else begin
            pcnt_nxt = pcnt + ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Period too long: report 0% or 100% from the current line level
    if (meas_tmo) begin
      state_nxt = WAIT_RISE;
      hcnt_nxt  = '0;
      pcnt_nxt  = '0;
      ratio_nxt = prev ? 8'hFF : 8'h00;
      hc_nxt    = '0;
      pc_nxt    = '0;
      valid_nxt = 1'b1;
      lost_nxt  = 1'b1;
    end

    // Hand a closed period to the divider; dropped if it is still busy
    if (period_close && !div_busy) begin
      div_busy_nxt = 1'b1;
      div_iter_nxt = 3'd0;
      div_rem_nxt  = {1'b0, hcnt};
      div_den_nxt  = pcnt;
      div_hlat_nxt = hcnt;
      div_quot_nxt = 8'h00;
    end
  end

  // State, counters, divider and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      hcnt         <= '0;
      pcnt         <= '0;
      div_busy     <= 1'b0;
      div_iter     <= 3'd0;
      div_rem      <= '0;
      div_den      <= '0;
      div_hlat     <= '0;
      div_quot     <= 8'h00;
      ratio        <= 8'h00;
      ratio_valid  <= 1'b0;
      high_count   <= '0;
      period_count <= '0;
      signal_lost  <= 1'b1;
    end else begin
      state        <= state_nxt;
      hcnt         <= hcnt_nxt;
      pcnt         <= pcnt_nxt;
      div_busy     <= div_busy_nxt;
      div_iter     <= div_iter_nxt;
      div_rem      <= div_rem_nxt;
      div_den      <= div_den_nxt;
      div_hlat     <= div_hlat_nxt;
      div_quot     <= div_quot_nxt;
      ratio        <= ratio_nxt;
      ratio_valid  <= valid_nxt;
      high_count   <= hc_nxt;
      period_count <= pc_nxt;
      signal_lost  <= lost_nxt;
    end
  end

endmodule
